// File: rtl/ddr_rd_engine.sv
// ddr_rd_engine: issues a run of 64-byte AXI4 INCR read bursts (8 beats x 8 bytes)
// starting at a 64-byte aligned base, keeping at most MAX_OUTSTANDING bursts in
// flight, and accumulates beat count, sticky error flag and an optional checksum.
// Optional feature: define DDR_RD_XSUM_EN to build the XOR checksum register;
// without it rd_xsum is tied to zero.
module ddr_rd_engine #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        RSTART_REG,
   input  logic [31:0] RADDR_REG,
   input  logic [31:0] RNBURST_REG,
   output logic        RIDLE_REG,
   output logic [31:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [63:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] rd_beats,
   output logic        rd_err,
   output logic [63:0] rd_xsum
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   state_t      state_q;
   logic [31:0] araddr_q;
   logic [15:0] nburst_q;
   logic [15:0] issued_q, issued_d;
   logic [3:0]  outst_q, outst_d;
   logic        arvalid_q;
   logic        rready_q;
   logic        ridle_q;
   logic [31:0] beats_q;
   logic        err_q;

   logic ar_hs, r_hs, rlast_hs, start_acc;

   assign ar_hs     = arvalid_q & m_axi_arready;
   assign r_hs      = m_axi_rvalid & rready_q;
   assign rlast_hs  = r_hs & m_axi_rlast;
   assign start_acc = (state_q == S_IDLE) & RSTART_REG & (|RNBURST_REG[15:0]);

   // Next values of the issue and in-flight counters from this cycle's handshakes.
   always_comb begin
      issued_d = issued_q + 16'(ar_hs);
      outst_d  = outst_q;
      case ({ar_hs, rlast_hs})
         2'b10:   outst_d = outst_q + 4'd1;
         2'b01:   outst_d = outst_q - 4'd1;
         default: outst_d = outst_q;
      endcase
   end

   // Job sequencer: state, AR channel, R acceptance and status registers.
   // NOTE: reset is synchronous here, so rstn is tested inside the clocked block
   // rather than listed in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         araddr_q  <= '0;
         nburst_q  <= '0;
         issued_q  <= '0;
         outst_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         ridle_q   <= 1'b1;
         beats_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         // Status accumulates on every accepted beat; a start below overrides it.
         if (r_hs) begin
            beats_q <= beats_q + 32'd1;
            if (|m_axi_rresp) err_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start_acc) begin
                  state_q   <= S_RUN;
                  araddr_q  <= {RADDR_REG[31:6], 6'b0};
                  nburst_q  <= RNBURST_REG[15:0];
                  issued_q  <= '0;
                  outst_q   <= '0;
                  arvalid_q <= 1'b1;
                  rready_q  <= 1'b1;
                  ridle_q   <= 1'b0;
                  beats_q   <= '0;
                  err_q     <= 1'b0;
               end
            end
            S_RUN: begin
               issued_q <= issued_d;
               outst_q  <= outst_d;
               if (ar_hs) araddr_q <= araddr_q + 32'd64;
               // A pending request is held until accepted; otherwise re-evaluate
               // against the post-handshake counters.
               if (!arvalid_q || ar_hs)
                  arvalid_q <= (issued_d < nburst_q) && (outst_d < MAX_OUT);
               if (ar_hs && (issued_d == nburst_q)) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               outst_q <= outst_d;
               if (rlast_hs && (outst_q == 4'd1)) begin
                  state_q  <= S_IDLE;
                  rready_q <= 1'b0;
                  ridle_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DDR_RD_XSUM_EN
   logic [63:0] xsum_q;

   // XOR checksum of accepted data beats, cleared on an accepted start.
   always_ff @(posedge clk) begin
      if (!rstn)          xsum_q <= '0;
      else if (start_acc) xsum_q <= '0;
      else if (r_hs)      xsum_q <= xsum_q ^ m_axi_rdata;
   end

   assign rd_xsum = xsum_q;

   logic unused_bits;
   assign unused_bits = ^{RADDR_REG[5:0], RNBURST_REG[31:16]};
`else
   assign rd_xsum = '0;

   logic unused_bits;
   assign unused_bits = ^{RADDR_REG[5:0], RNBURST_REG[31:16], m_axi_rdata};
`endif

   assign RIDLE_REG     = ridle_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = 8'd7;
   assign m_axi_arsize  = 3'd3;
   assign m_axi_arburst = 2'd1;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign rd_beats      = beats_q;
   assign rd_err        = err_q;

endmodule

// File: tb/tb_ddr_rd_engine.sv
// Scoreboard bench for ddr_rd_engine: expected AR addresses and per-job results
// are queued at start; monitors pop and compare as the DUT presents them.
module tb_ddr_rd_engine;

   typedef struct {
      logic [31:0] beats;
      logic        err;
      logic [63:0] xsum;
   } job_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        RSTART_REG;
   logic [31:0] RADDR_REG;
   logic [31:0] RNBURST_REG;
   logic        RIDLE_REG;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] rd_beats;
   logic        rd_err;
   logic [63:0] rd_xsum;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_addr[$];
   job_t        exp_jobs[$];
   bit          abort_pending = 0;

   // slave model state
   int pending   = 0;
   int beat      = 0;
   int job_beat  = 0;
   int hold      = 0;
   int err_beat  = -1;
   int ar_cnt    = 0;
   int rlast_cnt = 0;

   ddr_rd_engine #(.MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rstn(rstn),
      .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RNBURST_REG(RNBURST_REG),
      .RIDLE_REG(RIDLE_REG),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .rd_beats(rd_beats), .rd_err(rd_err), .rd_xsum(rd_xsum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave data is beat index + 1 in every burst, so one burst XORs to 0x8.
   function automatic logic [63:0] xsum_of(input int nb);
`ifdef DDR_RD_XSUM_EN
      return (nb % 2 == 1) ? 64'h8 : 64'h0;
`else
      return 64'h0 + 64'(nb & 0);
`endif
   endfunction

   // Zero-wait AXI read slave; rvalid can be withheld via 'hold'.
   initial begin
      bit s_ar, s_r;
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rresp  = '0;
      m_axi_rlast  = 1'b0;
      forever begin
         @(negedge clk);
         s_ar = m_axi_arvalid && m_axi_arready;
         s_r  = m_axi_rvalid && m_axi_rready;
         @(posedge clk);
         #2;
         if (!rstn) begin
            pending = 0;
            beat    = 0;
         end else begin
            if (s_ar) pending++;
            if (s_r) begin
               job_beat++;
               if (beat == 7) begin
                  beat = 0;
                  pending--;
               end else beat++;
            end
         end
         if (hold > 0) hold--;
         m_axi_rvalid = (pending > 0) && (hold == 0);
         m_axi_rdata  = 64'(beat + 1);
         m_axi_rlast  = (beat == 7);
         m_axi_rresp  = (job_beat == err_beat) ? 2'd2 : 2'd0;
      end
   end

   // Monitor: AR handshakes against expected addresses, job results on idle rise.
   initial begin
      logic ridle_prev = 1'b1;
      job_t j;
      forever begin
         @(negedge clk);
         if (rstn && m_axi_arvalid && m_axi_arready) begin
            ar_cnt++;
            if (exp_addr.size() == 0) check("ar_unexpected", 64'(m_axi_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("araddr", 64'(m_axi_araddr), 64'(exp_addr.pop_front()));
         end
         if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rlast_cnt++;
         if (!ridle_prev && RIDLE_REG) begin
            if (abort_pending) abort_pending = 0;
            else if (exp_jobs.size() == 0) check("job_unexpected", 64'(rd_beats), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               j = exp_jobs.pop_front();
               check("job_beats", 64'(rd_beats), 64'(j.beats));
               check("job_err", 64'(rd_err), 64'(j.err));
               check("job_xsum", rd_xsum, j.xsum);
               check("job_ar_left", 64'(exp_addr.size()), 64'h0);
            end
         end
         ridle_prev = RIDLE_REG;
      end
   end

   task automatic start_job(input logic [31:0] addr, input logic [31:0] nb, input int hold_cyc,
                            input logic exp_err, input bit aborted);
      logic [31:0] base;
      int          n;
      base = {addr[31:6], 6'b0};
      n    = int'(nb[15:0]);
      @(posedge clk);
      #1;
      job_beat    = 0;
      ar_cnt      = 0;
      rlast_cnt   = 0;
      hold        = hold_cyc;
      RSTART_REG  = 1'b1;
      RADDR_REG   = addr;
      RNBURST_REG = nb;
      if (n != 0) begin
         for (int k = 0; k < n; k++) exp_addr.push_back(base + 32'(k * 64));
         if (aborted) abort_pending = 1;
         else exp_jobs.push_back('{beats: 32'(n * 8), err: exp_err, xsum: xsum_of(n)});
      end
      @(posedge clk);
      #1;
      RSTART_REG = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!RIDLE_REG && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(RIDLE_REG), 64'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ridle"},   64'(RIDLE_REG),     64'h1);
      check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'h0);
      check({tag, "_rready"},  64'(m_axi_rready),  64'h0);
      check({tag, "_araddr"},  64'(m_axi_araddr),  64'h0);
      check({tag, "_beats"},   64'(rd_beats),      64'h0);
      check({tag, "_err"},     64'(rd_err),        64'h0);
      check({tag, "_xsum"},    rd_xsum,            64'h0);
   endtask

   initial begin
      int n, rl;
      rstn          = 1'b0;
      RSTART_REG    = 1'b0;
      RADDR_REG     = '0;
      RNBURST_REG   = '0;
      m_axi_arready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
      check("arlen",   64'(m_axi_arlen),   64'h7);
      check("arsize",  64'(m_axi_arsize),  64'h3);
      check("arburst", 64'(m_axi_arburst), 64'h1);

      // Basic two-burst job with a zero-wait slave.
      start_job(32'h1000_0000, 32'd2, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("basic_ridle_low",  64'(RIDLE_REG),     64'h0);
      check("basic_arvalid_up", 64'(m_axi_arvalid), 64'h1);
      check("basic_rready_up",  64'(m_axi_rready),  64'h1);
      check("basic_beats_clr",  64'(rd_beats),      64'h0);
      rl = 0;
      n  = 0;
      while (rl < 2 && n < 200) begin
         if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rl++;
         if (rl < 2) begin
            @(negedge clk);
            n++;
         end
      end
      check("basic_ridle_at_last", 64'(RIDLE_REG), 64'h0);
      @(negedge clk);
      check("basic_ridle_after_last", 64'(RIDLE_REG), 64'h1);
      repeat (2) @(negedge clk);

      // Throttling: rvalid withheld, at most four bursts in flight.
      start_job(32'h0000_8000, 32'd10, 50, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      check("thr_ar_count",    64'(ar_cnt),        64'h4);
      check("thr_arvalid_low", 64'(m_axi_arvalid), 64'h0);
      n = 0;
      while (!(m_axi_rvalid && m_axi_rready && m_axi_rlast) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("thr_ar_before_rlast", 64'(ar_cnt), 64'h4);
      wait_idle("thr_idle");
      check("thr_ar_total", 64'(ar_cnt), 64'd10);
      repeat (2) @(negedge clk);

      // Backpressure on AR with an ignored mid-job start; low address bits dropped.
      @(posedge clk);
      #1 m_axi_arready = 1'b0;
      start_job(32'h2000_0025, 32'd3, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_arvalid", 64'(m_axi_arvalid), 64'h1);
         check("bp_araddr",  64'(m_axi_araddr),  64'h2000_0000);
         @(posedge clk);
         #1;
         RSTART_REG  = (i == 1);
         RADDR_REG   = 32'h5000_0000;
         RNBURST_REG = 32'd7;
      end
      RSTART_REG    = 1'b0;
      m_axi_arready = 1'b1;
      wait_idle("bp_idle");
      repeat (2) @(negedge clk);

      // nburst of zero (upper bits are ignored) is not a start.
      start_job(32'h3000_0000, 32'h0001_0000, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("zero_ridle",   64'(RIDLE_REG),     64'h1);
         check("zero_arvalid", 64'(m_axi_arvalid), 64'h0);
      end

      // Error response on beat 3 stays sticky until the next start.
      err_beat = 3;
      start_job(32'h4000_0000, 32'd1, 0, 1'b1, 1'b0);
      wait_idle("err_idle");
      err_beat = -1;
      repeat (3) @(negedge clk);
      check("err_sticky", 64'(rd_err), 64'h1);

      // Address wrap at the top of the 32-bit space; start clears rd_err.
      start_job(32'hFFFF_FFC0, 32'd2, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("err_cleared", 64'(rd_err), 64'h0);
      wait_idle("wrap_idle");
      repeat (2) @(negedge clk);

      // Reset while draining abandons the job.
      err_beat = 0;
      start_job(32'h6000_0000, 32'd2, 0, 1'b0, 1'b1);
      n = 0;
      while (rd_beats < 32'd4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_pre_err", 64'(rd_err), 64'h1);
      rstn = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      @(posedge clk);
      #1 rstn = 1'b1;
      err_beat = -1;
      repeat (4) begin
         @(negedge clk);
         check("rst_quiet_arvalid", 64'(m_axi_arvalid), 64'h0);
      end

      // Recovery job after reset.
      start_job(32'h7000_0040, 32'd1, 0, 1'b0, 1'b0);
      wait_idle("final_idle");
      repeat (2) @(negedge clk);
      check("jobs_left", 64'(exp_jobs.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ddr_rd_engine.md
DDR_RD_ENGINE -- requirements
Module: ddr_rd_engine

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum number of AXI read bursts in flight (legal range 1..15).
REQ-002 Port: clk  in  1  single clock for all logic.
REQ-003 Port: rstn  in  1  reset; synchronous, active-low.
REQ-004 Port: RSTART_REG  in  1  one-cycle start pulse from the controller.
REQ-005 Port: RADDR_REG  in  32  byte start address; bits [5:0] are ignored and treated as 0.
REQ-006 Port: RNBURST_REG  in  32  number of 64-byte bursts; only bits [15:0] are used.
REQ-007 Port: RIDLE_REG  out  1  high when the engine is idle.
REQ-008 Port: m_axi_araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1  AXI4 read-address channel.
REQ-009 Port: m_axi_arready  in  1  AXI4 read-address ready.
REQ-010 Port: m_axi_rdata/rresp/rlast/rvalid  in  64/2/1/1  AXI4 read-data channel.
REQ-011 Port: m_axi_rready  out  1  AXI4 read-data ready.
REQ-012 Port: rd_beats  out  32  count of data beats accepted in the current job.
REQ-013 Port: rd_err  out  1  sticky flag: a non-OKAY response was seen in the current job.
REQ-014 Port: rd_xsum  out  64  XOR checksum of the data beats (see Configuration).

Function
REQ-015 arlen SHALL be constant 7, arsize constant 3, and arburst constant 1 (INCR), giving 8 beats x 8 bytes = 64 bytes per burst.
REQ-016 State machine SHALL have states IDLE, RUN and DRAIN:
- IDLE->RUN on RSTART_REG=1 with nburst!=0.
- RUN->DRAIN once all nburst AR handshakes are done.
- DRAIN->IDLE on the final rlast handshake.
REQ-017 RSTART_REG with nburst==0 SHALL be ignored (RIDLE_REG stays 1); RSTART_REG outside IDLE SHALL be ignored.
REQ-018 RIDLE_REG SHALL be registered and SHALL be 0 from the cycle after an accepted start until the cycle after the final rlast handshake.
REQ-019 On an accepted start, the engine SHALL latch the address and nburst, and clear rd_beats, rd_err and rd_xsum.
REQ-020 arvalid SHALL first rise the cycle after start.
REQ-021 araddr SHALL be base + 64*k for burst k, and SHALL stay stable while arvalid=1 and arready=0.
REQ-022 arvalid SHALL assert only when issued<nburst and outstanding<MAX_OUTSTANDING.
REQ-023 Once asserted, arvalid SHALL NOT drop before its handshake.
REQ-024 outstanding SHALL increment on an AR handshake and decrement on an R handshake with rlast=1; when both occur in the same cycle it SHALL be unchanged.
REQ-025 rready SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-026 Every R handshake SHALL increment rd_beats (32-bit, wraps).
REQ-027 Any R handshake with rresp!=0 SHALL set rd_err; rd_err SHALL stay set until the next accepted start.
REQ-028 Address arithmetic SHALL be 32-bit modulo, with no 4 KB check (64-byte aligned bursts never cross).
REQ-029 Completion SHALL be counted on rlast; the engine SHALL NOT check the beat count per burst.

Reset
REQ-030 rstn=0 at a clock edge SHALL force:
- state IDLE, RIDLE_REG=1;
- arvalid=0, rready=0;
- issued and outstanding counters=0;
- rd_beats=0, rd_err=0, rd_xsum=0, araddr=0.
REQ-031 Reset mid-job SHALL abandon in-flight bursts with no further AXI activity; an external interconnect reset is required alongside it.

Configuration
REQ-032 Macro DDR_RD_XSUM_EN: when defined, rd_xsum SHALL become rd_xsum XOR rdata on each R handshake (cleared on start).
REQ-033 When DDR_RD_XSUM_EN is not defined, rd_xsum SHALL be constant 0 and no checksum register SHALL exist.

Verification
REQ-034 Basic job: RADDR=0x1000_0000, nburst=2, arready=1, and a slave answering with 0 wait states -> araddr sequence 0x1000_0000, 0x1000_0040; rd_beats=16; RIDLE_REG low for the job and high one cycle after the second rlast.
REQ-035 Throttling: MAX_OUTSTANDING=4, nburst=10, slave withholds rvalid for 50 cycles -> exactly 4 AR handshakes then arvalid=0; AR issue resumes after the first rlast; final rd_beats=80.
REQ-036 Backpressure: arready held 0 for 5 cycles with arvalid=1 -> arvalid and araddr stable throughout; RSTART_REG pulsed mid-job is ignored; nburst=0 start -> RIDLE_REG never drops.
REQ-037 Error and edge: beat 3 returns rresp=2 -> rd_err=1 until the next start; RADDR=0xFFFF_FFC0 with nburst=2 -> second araddr=0x0000_0000.
REQ-038 Reset and checksum: rstn=0 during DRAIN -> all outputs at reset values the next cycle. With DDR_RD_XSUM_EN, data beats 0x1,0x2,...,0x8 (one burst) -> rd_xsum=0x8; without it -> rd_xsum=0.
